// File: rtl/l1_pmem_arbiter.sv
// l1_pmem_arbiter: merges L1 icache and dcache line requests onto one L2 port.
// One requester is granted at a time; the granted request is registered so L2
// sees stable read/write/address/wdata, and L2 data/resp are routed back.
// Optional macro ARB_RR_EN: round-robin tie-break instead of dcache priority.
module l1_pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic i_req, d_req;
  logic grant_i, grant_d;

  // Line-offset bits never reach L2; the address is line aligned when latched.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^{i_pmem_address[3:0], d_pmem_address[3:0]};

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_RR_EN
  // High when the dcache wins the next tie; it is the side not served last.
  logic prio_d_q, prio_d_d;

  // Tie-break by the round-robin pointer and advance it on every grant.
  always_comb begin
    grant_d  = d_req & (~i_req | prio_d_q);
    grant_i  = i_req & ~grant_d;
    prio_d_d = prio_d_q;
    if (state_q == S_IDLE) begin
      if (grant_d)      prio_d_d = 1'b0;
      else if (grant_i) prio_d_d = 1'b1;
    end
  end

  // Round-robin pointer register; starts favouring the dcache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_d_q <= 1'b1;
    else     prio_d_q <= prio_d_d;
  end
`else
  // Fixed priority: dcache wins every tie.
  always_comb begin
    grant_d = d_req;
    grant_i = i_req & ~d_req;
  end
`endif

  // Next-state logic: latch the winner's request in idle, release on l2_resp.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d = S_GNT_D;
          // A simultaneous dcache read waits until after the write-back.
          wr_d    = d_pmem_write;
          rd_d    = ~d_pmem_write;
          addr_d  = {d_pmem_address[ADDR_W-1:4], 4'h0};
          wdata_d = d_pmem_wdata;
        end else if (grant_i) begin
          state_d = S_GNT_I;
          wr_d    = 1'b0;
          rd_d    = 1'b1;
          addr_d  = {i_pmem_address[ADDR_W-1:4], 4'h0};
          wdata_d = '0;
        end
      end
      S_GNT_I, S_GNT_D: begin
        if (l2_resp) begin
          state_d = S_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase
  end

  // State and registered L2 request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign l2_read    = rd_q;
  assign l2_write   = wr_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;

  // Route L2 data and completion back to the granted requester only.
  always_comb begin
    i_pmem_resp  = (state_q == S_GNT_I) & l2_resp;
    d_pmem_resp  = (state_q == S_GNT_D) & l2_resp;
    i_pmem_rdata = (state_q == S_GNT_I) ? l2_rdata : '0;
    d_pmem_rdata = (state_q == S_GNT_D) ? l2_rdata : '0;
  end

endmodule

// File: tb/tb_l1_pmem_arbiter.sv
// Self-checking bench for l1_pmem_arbiter: directed table, hand-written corner
// sequences and randomized traffic, all checked against a transaction-level model.
module tb_l1_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;

  int checks = 0;
  int errors = 0;

  l1_pmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: who owns L2, and the latched request.
  int           m_owner;   // 0 none, 1 icache, 2 dcache
  bit           m_wr;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
`ifdef ARB_RR_EN
  int           m_prio;    // side that wins the next tie
`endif

  // DUT observations from the most recent checked cycle
  logic        obs_rd, obs_wr, obs_iresp, obs_dresp;
  logic [15:0] obs_addr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
`ifdef ARB_RR_EN
    m_prio  = 2;
`endif
  endtask

  task automatic model_compare();
    bit owned = (m_owner != 0);
    chk("l2_read",    l2_read,    owned && !m_wr);
    chk("l2_write",   l2_write,   owned && m_wr);
    chk("l2_address", l2_address, owned ? m_addr : 16'h0);
    chk("l2_wdata",   l2_wdata,   owned ? m_wdata : 128'h0);
    chk("i_resp",     i_pmem_resp, (m_owner == 1) && l2_resp);
    chk("d_resp",     d_pmem_resp, (m_owner == 2) && l2_resp);
    if (m_owner == 1 && l2_resp) chk("i_rdata", i_pmem_rdata, l2_rdata);
    else if (m_owner != 1)       chk("i_rdata_idle", i_pmem_rdata, 128'h0);
    if (m_owner == 2 && l2_resp) chk("d_rdata", d_pmem_rdata, l2_rdata);
    else if (m_owner != 2)       chk("d_rdata_idle", d_pmem_rdata, 128'h0);
  endtask

  task automatic model_update();
    int win;
    bit ir, dr;
    if (m_owner == 0) begin
      ir  = i_pmem_read;
      dr  = d_pmem_read | d_pmem_write;
      win = 0;
      if (ir && dr) begin
`ifdef ARB_RR_EN
        win = m_prio;
`else
        win = 2;
`endif
      end else if (dr) win = 2;
      else if (ir)     win = 1;
      if (win == 2) begin
        m_owner = 2;
        m_wr    = d_pmem_write;
        m_addr  = {d_pmem_address[15:4], 4'h0};
        m_wdata = d_pmem_wdata;
      end else if (win == 1) begin
        m_owner = 1;
        m_wr    = 1'b0;
        m_addr  = {i_pmem_address[15:4], 4'h0};
        m_wdata = '0;
      end
`ifdef ARB_RR_EN
      if (win != 0) m_prio = (win == 2) ? 1 : 2;
`endif
    end else if (l2_resp) begin
      m_owner = 0;
    end
  endtask

  // One clock: inputs are already set; check mid-cycle, then advance the model.
  task automatic step();
    @(negedge clk);
    model_compare();
    obs_rd    = l2_read;
    obs_wr    = l2_write;
    obs_addr  = l2_address;
    obs_iresp = i_pmem_resp;
    obs_dresp = d_pmem_resp;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    l2_rdata       = '0;
    l2_resp        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_l2_read",  l2_read,      1'b0);
    chk("rst_l2_write", l2_write,     1'b0);
    chk("rst_l2_addr",  l2_address,   16'h0);
    chk("rst_l2_wdata", l2_wdata,     128'h0);
    chk("rst_i_resp",   i_pmem_resp,  1'b0);
    chk("rst_d_resp",   d_pmem_resp,  1'b0);
    chk("rst_i_rdata",  i_pmem_rdata, 128'h0);
    chk("rst_d_rdata",  d_pmem_rdata, 128'h0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic         i_rd, d_rd, d_wr;
    logic [15:0]  i_addr, d_addr;
    logic [127:0] d_wdata;
    logic         resp;
    logic [127:0] rdata;
    logic         e_rd, e_wr;
    logic [15:0]  e_addr;
    logic         e_iresp, e_dresp;
  } vec_t;

  function automatic vec_t mk(logic i_rd, logic d_rd, logic d_wr, logic [15:0] i_addr,
                              logic [15:0] d_addr, logic [127:0] d_wdata, logic resp,
                              logic [127:0] rdata, logic e_rd, logic e_wr,
                              logic [15:0] e_addr, logic e_iresp, logic e_dresp);
    vec_t v;
    v.i_rd = i_rd; v.d_rd = d_rd; v.d_wr = d_wr; v.i_addr = i_addr; v.d_addr = d_addr;
    v.d_wdata = d_wdata; v.resp = resp; v.rdata = rdata; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_addr = e_addr; v.e_iresp = e_iresp; v.e_dresp = e_dresp;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    logic [127:0] a5;
    logic [127:0] ld;
    logic [1:0]   exp_gnt[4];
    int           pulses;

    a5 = {16{8'hA5}};
    ld = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // T1 icache fill with 3-cycle L2, T2 write-back then fill, T6 zero-latency
    //            i  dr dw iaddr     daddr     wdata resp rdata  erd ewr eaddr    ei ed
    tbl[0]  = mk(1, 0, 0, 16'h1234, 16'h0,    '0,   0,   '0,    0,  0,  16'h0,    0, 0);
    tbl[1]  = mk(1, 0, 0, 16'h1234, 16'h0,    '0,   0,   '0,    1,  0,  16'h1230, 0, 0);
    tbl[2]  = mk(1, 0, 0, 16'h1234, 16'h0,    '0,   0,   '0,    1,  0,  16'h1230, 0, 0);
    tbl[3]  = mk(1, 0, 0, 16'h1234, 16'h0,    '0,   1,   ld,    1,  0,  16'h1230, 1, 0);
    tbl[4]  = mk(0, 0, 0, 16'h0,    16'h0,    '0,   0,   '0,    0,  0,  16'h0,    0, 0);
    tbl[5]  = mk(0, 0, 1, 16'h0,    16'h8000, a5,   0,   '0,    0,  0,  16'h0,    0, 0);
    tbl[6]  = mk(0, 0, 1, 16'h0,    16'h8000, a5,   0,   '0,    0,  1,  16'h8000, 0, 0);
    tbl[7]  = mk(0, 0, 1, 16'h0,    16'h8000, a5,   1,   '0,    0,  1,  16'h8000, 0, 1);
    tbl[8]  = mk(0, 1, 0, 16'h0,    16'h801F, '0,   0,   '0,    0,  0,  16'h0,    0, 0);
    tbl[9]  = mk(0, 1, 0, 16'h0,    16'h801F, '0,   1,   ld,    1,  0,  16'h8010, 0, 1);
    tbl[10] = mk(1, 0, 0, 16'h4567, 16'h0,    '0,   0,   '0,    0,  0,  16'h0,    0, 0);
    tbl[11] = mk(1, 0, 0, 16'h4567, 16'h0,    '0,   1,   ~ld,   1,  0,  16'h4560, 1, 0);
    tbl[12] = mk(0, 0, 0, 16'h0,    16'h0,    '0,   0,   '0,    0,  0,  16'h0,    0, 0);

    do_reset();
    for (int k = 0; k < 13; k++) begin
      i_pmem_read    = tbl[k].i_rd;
      i_pmem_address = tbl[k].i_addr;
      d_pmem_read    = tbl[k].d_rd;
      d_pmem_write   = tbl[k].d_wr;
      d_pmem_address = tbl[k].d_addr;
      d_pmem_wdata   = tbl[k].d_wdata;
      l2_resp        = tbl[k].resp;
      l2_rdata       = tbl[k].rdata;
      step();
      chk($sformatf("tbl%0d_rd", k),    obs_rd,    tbl[k].e_rd);
      chk($sformatf("tbl%0d_wr", k),    obs_wr,    tbl[k].e_wr);
      chk($sformatf("tbl%0d_addr", k),  obs_addr,  tbl[k].e_addr);
      chk($sformatf("tbl%0d_iresp", k), obs_iresp, tbl[k].e_iresp);
      chk($sformatf("tbl%0d_dresp", k), obs_dresp, tbl[k].e_dresp);
    end

    // T3: both caches read every arbitration, four times, from a fresh pointer
    do_reset();
`ifdef ARB_RR_EN
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
`else
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b10;
`endif
    i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
    d_pmem_read = 1'b1; d_pmem_address = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      l2_resp = 1'b0;
      step();
      l2_resp  = 1'b1;
      l2_rdata = {4{$urandom}};
      step();
      chk($sformatf("t3_grant%0d", k), {obs_dresp, obs_iresp}, exp_gnt[k]);
    end
    idle_inputs();
    step();

    // Simultaneous dcache read and write: write first, read after the bubble
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h0340; d_pmem_wdata = a5;
    step();
    l2_resp = 1'b1;
    step();
    chk("rw_write_first", {obs_wr, obs_rd}, 2'b10);
    d_pmem_write = 1'b0; l2_resp = 1'b0;
    step();
    chk("rw_bubble", {obs_wr, obs_rd}, 2'b00);
    l2_resp = 1'b1;
    step();
    chk("rw_read_after", {obs_wr, obs_rd, obs_dresp}, 3'b011);
    idle_inputs();
    step();

    // T4: icache drops its request right after grant; the transfer still completes
    pulses = 0;
    i_pmem_read = 1'b1; i_pmem_address = 16'h0ABC;
    step();
    i_pmem_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      l2_resp = (k == 2);
      step();
      chk($sformatf("t4_hold%0d", k), obs_rd, 1'b1);
      pulses += int'(obs_iresp);
    end
    l2_resp = 1'b0;
    step();
    pulses += int'(obs_iresp);
    chk("t4_resp_pulses", pulses, 1);

    // T5: asynchronous reset in the middle of a transfer
    i_pmem_read = 1'b1; i_pmem_address = 16'h2228;
    step();
    i_pmem_read = 1'b0;
    step();
    #2;
    rst = 1'b1;
    l2_resp = 1'b1;
    #1;
    chk("t5_l2_read",  l2_read,     1'b0);
    chk("t5_i_resp",   i_pmem_resp, 1'b0);
    chk("t5_l2_addr",  l2_address,  16'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    l2_resp = 1'b0;
    d_pmem_read = 1'b1; d_pmem_address = 16'h3330;
    step();
    l2_resp = 1'b1;
    step();
    chk("t5_fresh_grant", {obs_rd, obs_dresp, obs_addr}, {2'b11, 16'h3330});
    idle_inputs();
    step();

    // Randomized traffic with random L2 latency
    for (int k = 0; k < 2000; k++) begin
      i_pmem_read    = ($urandom_range(0, 1) == 0);
      d_pmem_read    = ($urandom_range(0, 4) < 2);
      d_pmem_write   = ($urandom_range(0, 9) < 3);
      i_pmem_address = 16'($urandom);
      d_pmem_address = 16'($urandom);
      d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      l2_rdata       = {$urandom, $urandom, $urandom, $urandom};
      l2_resp        = (m_owner != 0) && ($urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
